key_conditioner: RTL and testbench



---
 rtl/key_pkg.sv | 26 ++
 rtl/key_debounce_ch.sv | 85 ++++++++
 rtl/key_conditioner.sv | 36 +++
 tb/tb_key_conditioner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and helpers for the key conditioning path.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a (no datapath).
package key_pkg;

    // Board defaults for the key conditioner.
    localparam int NUM_KEYS_DEF        = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam bit ACTIVE_LOW_DEF      = 1'b1;

    // Debounce counter width; it only has to reach DEBOUNCE_CYCLES-1.
    // Kept at least one bit wide so the smallest legal window (2) still
    // has a real counter.
    function automatic int cnt_width(input int cycles);
        if (cycles <= 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

    // Raw pin level of a key that is not being pressed.
    function automatic logic released_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// Single key channel: 2-flop synchroniser, debounce counter, level/pulse/toggle.
// Latency: a stable raw change shows on key_level_o at edge DEBOUNCE_CYCLES+2.
// Backpressure: none; outputs are free-running registered levels and pulses.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = ACTIVE_LOW_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_i,
    output logic key_level_o,
    output logic key_press_o,
    output logic key_release_o,
    output logic key_toggle_o
);

    localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic           RELEASED = released_level(ACTIVE_LOW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             sample_pressed;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             level_q,   level_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;
    logic             toggle_q,  toggle_d;

    // Polarity-normalised synchronised sample: 1 means the key is pressed.
    assign sample_pressed = sync2_q ^ RELEASED;

    // Debounce decision: any agreeing sample restarts the window; a full
    // window of disagreement commits the new level and fires its pulse.
    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        toggle_d  = toggle_q;
        if (sample_pressed == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            level_d   = sample_pressed;
            press_d   = sample_pressed;
            release_d = ~sample_pressed;
            if (sample_pressed) begin
                toggle_d = ~toggle_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; synchroniser presets to the released pin level so
    // leaving reset never looks like a key edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= RELEASED;
            sync2_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            sync1_q   <= key_raw_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign key_level_o   = level_q;
    assign key_press_o   = press_q;
    assign key_release_o = release_q;
    assign key_toggle_o  = toggle_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions raw board keys into clean level, press/release pulse and toggle.
// Latency: DEBOUNCE_CYCLES+2 edges from a stable raw change to key_level.
// Backpressure: none; every channel runs independently every cycle.
module key_conditioner
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = NUM_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = ACTIVE_LOW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_toggle
);

    // One fully independent debounce channel per key; no arbitration.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .key_raw_i     (key_raw[g]),
            .key_level_o   (key_level[g]),
            .key_press_o   (key_press[g]),
            .key_release_o (key_release[g]),
            .key_toggle_o  (key_toggle[g])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    localparam int NK  = 4;
    localparam int DB  = 4;
    localparam int LAT = DB + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_raw = 4'hF;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_toggle;

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_toggle  (key_toggle)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int            at_edge;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
    } pulse_t;

    pulse_t        exp_q[$];
    int            n_checks = 0;
    int            n_passed = 0;
    bit            mon_en   = 1'b0;
    logic [NK-1:0] exp_tog  = '0;

    // Scoreboard: every pulse the DUT emits is matched against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].at_edge < edge_n) begin
                n_checks++;
                $display("FAIL missed_pulse: expected press=%b release=%b at edge %0d, not observed by edge %0d",
                         exp_q[0].press, exp_q[0].rel, exp_q[0].at_edge, edge_n);
                void'(exp_q.pop_front());
            end
            if ((key_press | key_release) != '0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL spurious_pulse: got press=%b release=%b at edge %0d, expected none",
                             key_press, key_release, edge_n);
                end else begin
                    pulse_t e;
                    e = exp_q.pop_front();
                    if (e.at_edge !== edge_n || e.press !== key_press || e.rel !== key_release)
                        $display("FAIL pulse_match: got press=%b release=%b edge %0d, expected press=%b release=%b edge %0d",
                                 key_press, key_release, edge_n, e.press, e.rel, e.at_edge);
                    else
                        n_passed++;
                end
            end
        end
    end

    task automatic drive(input logic [NK-1:0] v, output int e);
        @(posedge clk);
        #1;
        key_raw = v;
        e = edge_n;
    endtask

    task automatic wait_edge(input int target);
        while (edge_n < target) @(negedge clk);
    endtask

    task automatic test_reset;
        int e;
        rst = 1'b1;
        key_raw = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        e = edge_n;
        @(negedge clk);
        n_checks++;
        if ({key_level, key_press, key_release, key_toggle} !== '0)
            $display("FAIL reset_outputs: got level=%b press=%b release=%b toggle=%b, expected all 0",
                     key_level, key_press, key_release, key_toggle);
        else
            n_passed++;
        mon_en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            wait_edge(e + i);
            n_checks++;
            if ({key_level, key_toggle} !== '0)
                $display("FAIL idle_after_reset: cycle %0d level=%b toggle=%b, expected 0000/0000",
                         i, key_level, key_toggle);
            else
                n_passed++;
        end
    endtask

    task automatic test_press;
        int            e;
        logic [NK-1:0] raw;
        raw = key_raw;
        raw[0] = 1'b0;
        drive(raw, e);
        exp_q.push_back('{e + LAT, 4'b0001, 4'b0000});
        exp_tog[0] = ~exp_tog[0];
        wait_edge(e + LAT - 1);
        n_checks++;
        if (key_level[0] !== 1'b0) $display("FAIL press_early: level0=%b expected 0", key_level[0]);
        else n_passed++;
        wait_edge(e + LAT);
        n_checks++;
        if (key_level[0] !== 1'b1 || key_toggle !== exp_tog)
            $display("FAIL press_level: level0=%b toggle=%b, expected 1 and %b", key_level[0], key_toggle, exp_tog);
        else n_passed++;
        wait_edge(e + LAT + 1);
        n_checks++;
        if (key_press[0] !== 1'b0 || key_level[0] !== 1'b1)
            $display("FAIL press_one_cycle: press0=%b level0=%b, expected 0 and 1", key_press[0], key_level[0]);
        else n_passed++;
    endtask

    task automatic test_glitch;
        int            e;
        int            e2;
        logic [NK-1:0] raw;
        raw = key_raw;
        raw[1] = 1'b0;
        drive(raw, e);
        raw[1] = 1'b1;
        wait_edge(e + 2);
        drive(raw, e2);
        for (int i = 1; i <= 12; i++) begin
            wait_edge(e + i);
            n_checks++;
            if (key_level[1] !== 1'b0 || key_toggle[1] !== 1'b0)
                $display("FAIL glitch_rejected: cycle %0d level1=%b toggle1=%b, expected 0/0",
                         i, key_level[1], key_toggle[1]);
            else
                n_passed++;
        end
    endtask

    task automatic test_back_to_back;
        int            e;
        logic [NK-1:0] raw;
        for (int k = 0; k < 2; k++) begin
            raw = key_raw;
            raw[2] = 1'b0;
            drive(raw, e);
            exp_q.push_back('{e + LAT, 4'b0100, 4'b0000});
            exp_tog[2] = ~exp_tog[2];
            wait_edge(e + LAT - 1);
            n_checks++;
            if (key_level[2] !== 1'b0) $display("FAIL k2_press_early: round %0d level2=%b expected 0", k, key_level[2]);
            else n_passed++;
            wait_edge(e + LAT);
            n_checks++;
            if (key_level[2] !== 1'b1 || key_toggle !== exp_tog)
                $display("FAIL k2_press: round %0d level2=%b toggle=%b, expected 1 and %b", k, key_level[2], key_toggle, exp_tog);
            else n_passed++;
            wait_edge(e + LAT + 2);
            raw = key_raw;
            raw[2] = 1'b1;
            drive(raw, e);
            exp_q.push_back('{e + LAT, 4'b0000, 4'b0100});
            wait_edge(e + LAT - 1);
            n_checks++;
            if (key_level[2] !== 1'b1) $display("FAIL k2_release_early: round %0d level2=%b expected 1", k, key_level[2]);
            else n_passed++;
            wait_edge(e + LAT);
            n_checks++;
            if (key_level[2] !== 1'b0 || key_toggle !== exp_tog)
                $display("FAIL k2_release: round %0d level2=%b toggle=%b, expected 0 and %b", k, key_level[2], key_toggle, exp_tog);
            else n_passed++;
            wait_edge(e + LAT + 2);
        end
    endtask

    task automatic test_simultaneous;
        int e;
        @(posedge clk);
        #1;
        rst = 1'b1;
        key_raw = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_tog = '0;
        drive(4'b0000, e);
        exp_q.push_back('{e + LAT, 4'b1111, 4'b0000});
        exp_tog = 4'b1111;
        wait_edge(e + LAT);
        n_checks++;
        if (key_level !== 4'b1111 || key_toggle !== exp_tog)
            $display("FAIL simultaneous: level=%b toggle=%b, expected 1111 and %b", key_level, key_toggle, exp_tog);
        else n_passed++;
        wait_edge(e + LAT + 2);
    endtask

    task automatic test_reset_mid;
        int e;
        int r;
        @(posedge clk);
        #1;
        rst = 1'b1;
        key_raw = 4'b0111;
        e = edge_n;
        wait_edge(e + 1);
        n_checks++;
        if ({key_level, key_press, key_release, key_toggle} !== '0)
            $display("FAIL reset_mid_outputs: level=%b press=%b release=%b toggle=%b, expected all 0",
                     key_level, key_press, key_release, key_toggle);
        else n_passed++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        r = edge_n;
        exp_tog = 4'b1000;
        exp_q.push_back('{r + LAT, 4'b1000, 4'b0000});
        wait_edge(r + LAT - 1);
        n_checks++;
        if (key_level !== 4'b0000) $display("FAIL reset_repress_early: level=%b expected 0000", key_level);
        else n_passed++;
        wait_edge(r + LAT);
        n_checks++;
        if (key_level !== 4'b1000 || key_toggle !== exp_tog)
            $display("FAIL reset_repress: level=%b toggle=%b, expected 1000 and %b", key_level, key_toggle, exp_tog);
        else n_passed++;
        wait_edge(r + LAT + 5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        repeat (10) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d expected pulses never observed, expected 0", exp_q.size());
        else
            n_passed++;
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
